// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the RAM stream reader: default
//               data/address widths and the burst FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  // Default widths used by blocks that attach to the result RAM
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;

  // Burst controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ram_stream_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count and a registered head
//               word. The head register is refreshed on the clock edge so the
//               output data never depends combinationally on i_pop.
//               DEPTH must be a power of two and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,      // asynchronous, active low
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rptr_inc;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees a slot in the same cycle.
  assign w_pop      = i_pop && (r_count != '0);
  assign w_push     = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);
  assign w_rptr_inc = r_rptr + AW'(1);

  // Storage array write port; contents need no reset since the count gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer, occupancy and head-register maintenance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      // Head follows the oldest stored word. With two or more entries the
      // next word is already in the array; otherwise it is the word arriving.
      if (w_pop) begin
        if (r_count > (AW+1)'(1)) begin
          r_head <= r_mem[w_rptr_inc];
        end else if (w_push) begin
          r_head <= i_data;
        end
      end else if (w_push && (r_count == '0)) begin
        r_head <= i_data;
      end
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader
// Description : Issues a burst of sequential RAM reads on a start pulse and
//               streams the returned words over a valid/ready interface.
//               Reads are issued only when the output buffer can absorb
//               every word already in flight, so no data is ever dropped.
//               Optional macro RAM_READER_CHECKSUM_EN adds a running XOR
//               checksum output over the words accepted in the burst.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
  import risc_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef RAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // Occupancy counters share the FIFO count width
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;

  // Read-latency tracker: a valid bit and a last-word tag per pipeline stage
  logic [RD_LAT-1:0] r_lat_vld;
  logic [RD_LAT-1:0] r_lat_last;

  logic              w_start_acc;
  logic              w_credit;
  logic              w_issue;
  logic              w_last_issue;
  logic [CNT_W-1:0]  w_inflight;
  logic [CNT_W:0]    w_occupancy;

  logic              w_fifo_valid;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W:0]   w_fifo_head;
  logic              w_pop;

  assign w_start_acc  = (r_state == ST_IDLE) && start;
  assign w_occupancy  = {1'b0, w_fifo_count} + {1'b0, w_inflight};
  assign w_credit     = (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign w_issue      = (r_state == ST_ISSUE) && w_credit;
  assign w_last_issue = w_issue && (r_remaining == ADDR_W'(1));
  assign w_pop        = w_fifo_valid && out_ready;

  // Count reads issued but not yet returned by the RAM
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CNT_W'(r_lat_vld[i]);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (length == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_last_issue) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Every read has returned and the buffer has been fully unloaded
        if ((w_inflight == '0) && !w_fifo_valid) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        busy      = 1'b1;
        mem_rd_en = w_credit;
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Burst address and remaining-word counter; address wraps at 2^ADDR_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_start_acc) begin
      r_addr      <= base_addr;
      r_remaining <= length;
    end else if (w_issue) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - ADDR_W'(1);
    end
  end

  assign mem_addr = r_addr;

  // Shift each issued read down the latency pipeline, tagging the last one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_vld  <= '0;
      r_lat_last <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_lat_vld[i]  <= r_lat_vld[i-1];
        r_lat_last[i] <= r_lat_last[i-1];
      end
      r_lat_vld[0]  <= w_issue;
      r_lat_last[0] <= w_last_issue;
    end
  end

  // Output buffer carries the last-word tag alongside the data
  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_lat_vld[RD_LAT-1]),
    .i_data  ({r_lat_last[RD_LAT-1], mem_rd_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign out_valid = w_fifo_valid;
  assign out_data  = w_fifo_head[DATA_W-1:0];
  // The stored tag is qualified so a stale head never shows last while idle
  assign out_last  = w_fifo_head[DATA_W] && w_fifo_valid;

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running XOR of accepted words, cleared when a new burst is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum ^ out_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire
